// File: rtl/fir_out_buffer.sv
// Output stage of the FIR: rounds and saturates each accumulator value to an
// OUT_W-bit sample, queues it in a small FIFO and serves it over valid/ready.
module fir_out_buffer #(
    parameter int ACC_W = 19,
    parameter int SHIFT = 8,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [31:0]              RESULT,
    input  logic                     OUTPUT_DATA_READY,
    output logic [OUT_W-1:0]         OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [$clog2(DEPTH):0]   FIFO_COUNT,
    output logic [CNT_W-1:0]         SAT_CNT,
    output logic [CNT_W-1:0]         DROP_CNT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic signed [ACC_W:0] RND    = (ACC_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-(2 ** (OUT_W - 1)));

    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic logic signed [ACC_W:0] round_shr(input logic [ACC_W-1:0] x);
        logic signed [ACC_W:0] sum;
        sum = $signed({x[ACC_W-1], x}) + RND;
        return sum >>> SHIFT;
    endfunction

    // Returns {clipped, sample}.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] r);
        if (r > SAT_HI) return {1'b1, SAT_HI[OUT_W-1:0]};
        if (r < SAT_LO) return {1'b1, SAT_LO[OUT_W-1:0]};
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [OUT_W:0]         w_conv;
    logic                   w_clip;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_push;
    logic                   w_drop;

    logic signed [OUT_W-1:0] r_data_p1;
    logic                   r_vld_p1;
    logic [CNT_W-1:0]       r_sat_cnt;
    logic [CNT_W-1:0]       r_drop_cnt;
    logic [OUT_W-1:0]       r_mem [DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;

    assign w_conv = saturate(round_shr(RESULT[ACC_W-1:0]));
    assign w_clip = w_conv[OUT_W];

    // Stage 1: registered conversion
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_vld_p1  <= 1'b0;
            r_sat_cnt <= '0;
        end else begin
            r_vld_p1 <= OUTPUT_DATA_READY;
            if (OUTPUT_DATA_READY && w_clip)
                r_sat_cnt <= cnt_inc(r_sat_cnt);
        end
    end

    always_ff @(posedge CLK) begin
        r_data_p1 <= $signed(w_conv[OUT_W-1:0]);
    end

    // Stage 2: FIFO push; a full FIFO still accepts when the head leaves this edge
    assign w_pop  = (r_count != '0) && OUT_READY;
    assign w_full = (r_count == CW'(DEPTH));
    assign w_push = r_vld_p1 && (!w_full || w_pop);
    assign w_drop = r_vld_p1 && !w_push;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)
                r_drop_cnt <= cnt_inc(r_drop_cnt);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_data_p1;
    end

    // Head is read straight from storage; it only moves on a pop, so it holds under stall.
    assign OUT_VALID  = (r_count != '0);
    assign OUT_DATA   = OUT_VALID ? r_mem[r_rd_ptr] : '0;
    assign FIFO_COUNT = r_count;
    assign SAT_CNT    = r_sat_cnt;
    assign DROP_CNT   = r_drop_cnt;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Scoreboard bench for fir_out_buffer: expected samples are queued as strobes are driven.
module tb_fir_out_buffer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] RESULT;
    logic        OUTPUT_DATA_READY;
    logic [7:0]  OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [2:0]  FIFO_COUNT;
    logic [15:0] SAT_CNT;
    logic [15:0] DROP_CNT;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_sat  = 0;
    int exp_drop = 0;
    logic [7:0] q[$];

    fir_out_buffer dut (
        .CLK(CLK), .RESET(RESET), .RESULT(RESULT),
        .OUTPUT_DATA_READY(OUTPUT_DATA_READY),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .FIFO_COUNT(FIFO_COUNT), .SAT_CNT(SAT_CNT), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference conversion: round half up of x/256, clip to int8.
    task automatic model(input logic [31:0] res, output logic [7:0] val, output bit clip);
        logic [18:0] a;
        int x;
        int r;
        a = res[18:0];
        x = $signed(a);
        r = int'($floor(real'(x) / 256.0 + 0.5));
        clip = 1'b0;
        if (r > 127)  begin r = 127;  clip = 1'b1; end
        if (r < -128) begin r = -128; clip = 1'b1; end
        val = 8'(r);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // One-cycle strobe; returns just after the edge that sampled it.
    task automatic send(input logic [31:0] res, input bit drop);
        logic [7:0] v;
        bit c;
        model(res, v, c);
        if (c) exp_sat++;
        if (drop) exp_drop++;
        else q.push_back(v);
        RESULT = res;
        OUTPUT_DATA_READY = 1'b1;
        tick(1);
        OUTPUT_DATA_READY = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (!RESET && OUT_VALID) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 32'(OUT_VALID), 32'd0);
            end else begin
                chk("out_data", 32'(OUT_DATA), 32'(q[0]));
                if (OUT_READY) void'(q.pop_front());
            end
        end
    end

    initial begin
        RESET = 1'b1;
        RESULT = '0;
        OUTPUT_DATA_READY = 1'b0;
        OUT_READY = 1'b0;
        tick(3);
        RESET = 1'b0;
        chk("rst_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_data",  32'(OUT_DATA), 32'd0);
        chk("rst_count", 32'(FIFO_COUNT), 32'd0);
        chk("rst_sat",   32'(SAT_CNT), 32'd0);
        chk("rst_drop",  32'(DROP_CNT), 32'd0);

        // latency: valid two edges after the strobe
        OUT_READY = 1'b1;
        send(32'h0000_0400, 1'b0);
        chk("lat_valid_early", 32'(OUT_VALID), 32'd0);
        tick(1);
        chk("lat_valid", 32'(OUT_VALID), 32'd1);
        chk("lat_data",  32'(OUT_DATA), 32'h04);
        tick(2);

        // rounding and saturation at full rate
        send(32'h0000_0480, 1'b0);
        send(32'h0007_FB80, 1'b0);
        send(32'h7FF8_0400, 1'b0);
        send(32'h0007_FF80, 1'b0);
        send(32'h0003_FFFF, 1'b0);
        send(32'h0004_0000, 1'b0);
        tick(5);
        chk("sat_cnt",   32'(SAT_CNT), 32'(exp_sat));
        chk("sat_cnt2",  32'(SAT_CNT), 32'd2);
        chk("idle_count", 32'(FIFO_COUNT), 32'd0);

        // overflow: six strobes into a stalled FIFO
        OUT_READY = 1'b0;
        for (int i = 0; i < 6; i++)
            send(32'(300 * (i + 1)), i >= 4);
        tick(1);
        chk("ovf_count", 32'(FIFO_COUNT), 32'd4);
        chk("ovf_drop",  32'(DROP_CNT), 32'(exp_drop));
        chk("ovf_valid", 32'(OUT_VALID), 32'd1);
        OUT_READY = 1'b1;
        tick(3);
        chk("drain_valid", 32'(OUT_VALID), 32'd1);
        chk("drain_count", 32'(FIFO_COUNT), 32'd1);
        tick(1);
        chk("drain_empty", 32'(OUT_VALID), 32'd0);
        chk("drain_count0", 32'(FIFO_COUNT), 32'd0);

        // full FIFO with simultaneous pop accepts the new sample
        OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++)
            send(32'h0001_0000 - 32'(i * 4096), 1'b0);
        chk("full_count", 32'(FIFO_COUNT), 32'd4);
        OUT_READY = 1'b1;
        tick(1);
        OUT_READY = 1'b0;
        chk("fullpop_count", 32'(FIFO_COUNT), 32'd4);
        chk("fullpop_drop",  32'(DROP_CNT), 32'(exp_drop));
        OUT_READY = 1'b1;
        tick(6);
        chk("fullpop_drained", 32'(FIFO_COUNT), 32'd0);
        chk("sb_empty1", 32'(q.size()), 32'd0);

        // reset mid-operation with a sample in flight
        OUT_READY = 1'b0;
        send(32'h0000_0100, 1'b0);
        send(32'h0000_0200, 1'b0);
        send(32'h0000_0300, 1'b0);
        tick(1);
        chk("pre_rst_count", 32'(FIFO_COUNT), 32'd3);
        RESULT = 32'h0000_0700;
        OUTPUT_DATA_READY = 1'b1;
        tick(1);
        OUTPUT_DATA_READY = 1'b0;
        RESET = 1'b1;
        q.delete();
        exp_sat = 0;
        exp_drop = 0;
        tick(1);
        RESET = 1'b0;
        chk("mid_rst_valid", 32'(OUT_VALID), 32'd0);
        chk("mid_rst_count", 32'(FIFO_COUNT), 32'd0);
        chk("mid_rst_sat",   32'(SAT_CNT), 32'(exp_sat));
        chk("mid_rst_drop",  32'(DROP_CNT), 32'(exp_drop));
        chk("mid_rst_data",  32'(OUT_DATA), 32'd0);
        OUT_READY = 1'b1;
        tick(4);
        chk("inflight_gone", 32'(FIFO_COUNT), 32'd0);
        chk("inflight_valid", 32'(OUT_VALID), 32'd0);
        chk("sb_empty2", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
